exe_stage: RTL and testbench

- Execute stage; sits on the receiving end of the ID→EXE bus. The ID stage produces the 158-bit EXE_signal and its valid; this block consumes them.
- Owns the EXE pipeline register and valid/allowin handshake toward ID.
- Computes the ALU result, including single-cycle multiply and an iterative 32-step divider.
- Issues data SRAM requests and drives the 71-bit EXE→MEM bus plus hazard/forward info back to ID.

---
 rtl/exe_stage_if.sv | 32 +++
 rtl/exe_stage.sv | 163 ++++++++++++++++
 tb/tb_exe_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// ID->EXE->MEM bundle: instruction bus and handshake in, MEM bus, data SRAM request and hazard info out.
// master drives the EXE inputs (ID side and MEM allowin); slave is the execute stage itself.
interface exe_stage_if;
    logic         EXE_signal_valid;
    logic [157:0] EXE_signal;
    logic         MEM_allowin;
    logic         EXE_allowin;
    logic         MEM_signal_valid;
    logic [70:0]  MEM_signal;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         EXE_rf_we;
    logic [4:0]   EXE_rf_waddr;
    logic         EXE_res_from_mem;
    logic [31:0]  EXE_result;

    modport master (
        output EXE_signal_valid, EXE_signal, MEM_allowin,
        input  EXE_allowin, MEM_signal_valid, MEM_signal,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               EXE_rf_we, EXE_rf_waddr, EXE_res_from_mem, EXE_result
    );

    modport slave (
        input  EXE_signal_valid, EXE_signal, MEM_allowin,
        output EXE_allowin, MEM_signal_valid, MEM_signal,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               EXE_rf_we, EXE_rf_waddr, EXE_res_from_mem, EXE_result
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, ALU with single-cycle multiply and iterative restoring divider.
// Latency: 1 cycle for non-divide ops; divides occupy the stage for DIV_STEPS+2 cycles.
// Backpressure: holds payload and result while MEM_allowin=0; EXE_allowin drops while busy or stalled.
module exe_stage #(
    parameter int DIV_STEPS = 32
) (
    input  logic       clk,
    input  logic       reset,
    exe_stage_if.slave io
);
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rkd_value;
        logic        res_from_mem;
        logic [3:0]  mem_we;
        logic [18:0] alu_op;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
    } exe_payload_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    localparam int CW = $clog2(DIV_STEPS + 1);

    exe_payload_t pl;
    logic         exe_valid;
    logic         exe_readygo;
    logic         exe_allowin;
    div_state_t   div_state, div_next;
    logic [CW-1:0] div_cnt;
    logic [31:0]  div_rem, div_quo, div_dsor;
    logic         q_neg, r_neg;
    logic         is_div, op_signed;
    logic [31:0]  a, b, a_abs, b_abs;
    logic [32:0]  rem_shift;
    logic         rem_ge;
    logic [31:0]  div_q, div_r;
    logic [63:0]  prod_s;
    logic [31:0]  mulhu;
    logic [4:0]   sh;
    logic [31:0]  alu_result;
    logic         mem_req;

    assign a         = pl.alu_src1;
    assign b         = pl.alu_src2;
    assign sh        = b[4:0];
    assign is_div    = exe_valid & (|pl.alu_op[18:15]);
    assign op_signed = pl.alu_op[15] | pl.alu_op[17];

    assign exe_allowin = !exe_valid | (exe_readygo & io.MEM_allowin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_valid <= 1'b0;
            pl        <= '0;
        end else if (exe_allowin) begin
            exe_valid <= io.EXE_signal_valid;
            if (io.EXE_signal_valid)
                pl <= io.EXE_signal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_state <= DIV_IDLE;
        else       div_state <= div_next;
    end

    always_comb begin
        div_next    = div_state;
        exe_readygo = 1'b1;
        case (div_state)
            DIV_IDLE: begin
                if (is_div) begin
                    div_next    = DIV_BUSY;
                    exe_readygo = 1'b0;
                end
            end
            DIV_BUSY: begin
                exe_readygo = 1'b0;
                if (div_cnt == CW'(DIV_STEPS - 1))
                    div_next = DIV_DONE;
            end
            DIV_DONE: begin
                if (io.MEM_allowin)
                    div_next = DIV_IDLE;
            end
            default: div_next = DIV_IDLE;
        endcase
    end

    // Dividend is shifted out of the top of div_quo while quotient bits enter at the bottom.
    assign a_abs     = (op_signed & a[31]) ? (32'd0 - a) : a;
    assign b_abs     = (op_signed & b[31]) ? (32'd0 - b) : b;
    assign rem_shift = {div_rem, div_quo[31]};
    assign rem_ge    = rem_shift >= {1'b0, div_dsor};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            div_rem  <= '0;
            div_quo  <= '0;
            div_dsor <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (div_state == DIV_IDLE && is_div) begin
            div_cnt  <= '0;
            div_rem  <= '0;
            div_quo  <= a_abs;
            div_dsor <= b_abs;
            // Divide by zero keeps the all-ones quotient unsigned-looking, so no negation.
            q_neg    <= op_signed & (a[31] ^ b[31]) & (|b);
            r_neg    <= op_signed & a[31];
        end else if (div_state == DIV_BUSY) begin
            div_cnt <= div_cnt + 1'b1;
            div_rem <= rem_ge ? 32'(rem_shift - {1'b0, div_dsor}) : rem_shift[31:0];
            div_quo <= {div_quo[30:0], rem_ge};
        end
    end

    assign div_q = q_neg ? (32'd0 - div_quo) : div_quo;
    assign div_r = r_neg ? (32'd0 - div_rem) : div_rem;

    // Unsigned high word derived from the signed product by correcting for each operand's sign bit.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign mulhu  = prod_s[63:32] + (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);

    always_comb begin
        alu_result = '0;
        if (pl.alu_op[0])  alu_result = a + b;
        if (pl.alu_op[1])  alu_result = a - b;
        if (pl.alu_op[2])  alu_result = {31'd0, $signed(a) < $signed(b)};
        if (pl.alu_op[3])  alu_result = {31'd0, a < b};
        if (pl.alu_op[4])  alu_result = a & b;
        if (pl.alu_op[5])  alu_result = ~(a | b);
        if (pl.alu_op[6])  alu_result = a | b;
        if (pl.alu_op[7])  alu_result = a ^ b;
        if (pl.alu_op[8])  alu_result = a << sh;
        if (pl.alu_op[9])  alu_result = a >> sh;
        if (pl.alu_op[10]) alu_result = $signed(a) >>> sh;
        if (pl.alu_op[11]) alu_result = b;
        if (pl.alu_op[12]) alu_result = prod_s[31:0];
        if (pl.alu_op[13]) alu_result = prod_s[63:32];
        if (pl.alu_op[14]) alu_result = mulhu;
        if (pl.alu_op[15] | pl.alu_op[16]) alu_result = div_q;
        if (pl.alu_op[17] | pl.alu_op[18]) alu_result = div_r;
    end

    assign mem_req = pl.res_from_mem | (|pl.mem_we);

    assign io.EXE_allowin      = exe_allowin;
    assign io.MEM_signal_valid = exe_valid & exe_readygo;
    assign io.MEM_signal       = {pl.pc, pl.rf_we, pl.rf_waddr, pl.res_from_mem, alu_result};
    assign io.data_sram_en     = exe_valid & exe_readygo & io.MEM_allowin & mem_req;
    assign io.data_sram_we     = {4{io.data_sram_en}} & pl.mem_we;
    assign io.data_sram_addr   = alu_result;
    assign io.data_sram_wdata  = pl.rkd_value;
    assign io.EXE_rf_we        = exe_valid & pl.rf_we;
    assign io.EXE_rf_waddr     = pl.rf_waddr;
    assign io.EXE_res_from_mem = exe_valid & pl.res_from_mem;
    assign io.EXE_result       = alu_result;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus randomized ops under random MEM backpressure,
// scored by an arithmetic reference model through an expectation queue and a separate monitor.
module tb_exe_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exe_stage_if io();
    exe_stage #(.DIV_STEPS(32)) dut (.clk(clk), .reset(reset), .io(io));

    typedef struct packed {
        logic [70:0] mem_sig;
        logic        mem_op;
        logic [3:0]  we;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          bp_mode = 1'b0;
    logic [31:0] pc_cnt = 32'h1c00_0000;

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sbv, sp;
        logic [63:0] up;
        logic [4:0]  sh;
        sa  = $signed(a);
        sbv = $signed(b);
        sp  = sa * sbv;
        up  = {32'd0, a} * {32'd0, b};
        sh  = b[4:0];
        if (op[0])  return a + b;
        if (op[1])  return a - b;
        if (op[2])  return (sa < sbv) ? 32'd1 : 32'd0;
        if (op[3])  return (a < b) ? 32'd1 : 32'd0;
        if (op[4])  return a & b;
        if (op[5])  return ~(a | b);
        if (op[6])  return a | b;
        if (op[7])  return a ^ b;
        if (op[8])  return a << sh;
        if (op[9])  return a >> sh;
        if (op[10]) return 32'(sa >>> sh);
        if (op[11]) return b;
        if (op[12]) return up[31:0];
        if (op[13]) return sp[63:32];
        if (op[14]) return up[63:32];
        if (op[15]) return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sbv);
        if (op[16]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (op[17]) return (b == 0) ? a : 32'(sa % sbv);
        if (op[18]) return (b == 0) ? a : a % b;
        return 32'd0;
    endfunction

    function automatic logic [157:0] mk(input logic [31:0] pc, input logic rf_we, input logic [4:0] wa,
                                        input logic [31:0] rkd, input logic rfm, input logic [3:0] mwe,
                                        input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
        return {pc, rf_we, wa, rkd, rfm, mwe, op, a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) io.MEM_allowin = ($urandom_range(0, 3) != 0);
    endtask

    // Present one instruction until accepted; record its expected MEM-side response.
    task automatic issue(input logic [157:0] sig);
        int          n;
        exp_t        e;
        logic [159:0] g;
        n = 0;
        io.EXE_signal_valid = 1'b1;
        io.EXE_signal       = sig;
        forever begin
            @(negedge clk);
            if (io.EXE_allowin) break;
            n++;
            if (n > 200) break;
            tick();
        end
        if (n > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: allowin low for %0d cycles, required at most 200", n);
        end else begin
            e.mem_sig = {sig[157:126], sig[125], sig[124:120], sig[87], ref_alu(sig[82:64], sig[63:32], sig[31:0])};
            e.mem_op  = sig[87] | (|sig[86:83]);
            e.we      = sig[86:83];
            e.wdata   = sig[119:88];
            sb.push_back(e);
        end
        tick();
        g = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        io.EXE_signal_valid = 1'b0;
        io.EXE_signal       = g[157:0];
        pc_cnt += 32'd4;
    endtask

    task automatic op_check(input string name, input logic [18:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        int n;
        n = 0;
        issue(mk(pc_cnt, 1'b1, 5'd3, 32'd0, 1'b0, 4'h0, op, a, b));
        forever begin
            @(negedge clk);
            if (io.EXE_allowin) break;
            n++;
            if (n > 100) break;
        end
        check({name, "_stall"}, 71'(n), 71'(exp_stall));
        check({name, "_valid"}, 71'(io.MEM_signal_valid), 71'(1));
        check({name, "_result"}, 71'(io.MEM_signal[31:0]), 71'(exp_res));
        tick();
    endtask

    // Monitor: every handoff to MEM is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (io.MEM_signal_valid && io.MEM_allowin) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got MEM_signal %0h, required no output", io.MEM_signal);
                end else begin
                    e = sb.pop_front();
                    check("mem_signal", io.MEM_signal, e.mem_sig);
                    check("fwd_result", 71'(io.EXE_result), 71'(e.mem_sig[31:0]));
                    check("fwd_rf_we", 71'(io.EXE_rf_we), 71'(e.mem_sig[38]));
                    check("fwd_rf_waddr", 71'(io.EXE_rf_waddr), 71'(e.mem_sig[37:33]));
                    check("fwd_res_from_mem", 71'(io.EXE_res_from_mem), 71'(e.mem_sig[32]));
                    check("sram_en", 71'(io.data_sram_en), 71'(e.mem_op));
                    check("sram_we", 71'(io.data_sram_we), 71'(e.mem_op ? e.we : 4'h0));
                    if (e.mem_op) begin
                        check("sram_addr", 71'(io.data_sram_addr), 71'(e.mem_sig[31:0]));
                        check("sram_wdata", 71'(io.data_sram_wdata), 71'(e.wdata));
                    end
                end
            end else begin
                check("sram_idle", 71'({io.data_sram_en, io.data_sram_we}), 71'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] op;
        logic [31:0] a, b;
        logic        rfm, seen;
        logic [3:0]  mwe;
        int          k, n;

        io.EXE_signal_valid = 1'b0;
        io.EXE_signal       = '0;
        io.MEM_allowin      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_allowin", 71'(io.EXE_allowin), 71'(1));
        check("rst_mem_valid", 71'(io.MEM_signal_valid), 71'(0));
        check("rst_sram_en", 71'(io.data_sram_en), 71'(0));
        check("rst_sram_we", 71'(io.data_sram_we), 71'(0));
        check("rst_rf_we", 71'(io.EXE_rf_we), 71'(0));
        check("rst_res_from_mem", 71'(io.EXE_res_from_mem), 71'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        op_check("add", 19'd1, 32'd5, 32'hFFFF_FFFF, 32'd4, 0);

        // Store held by MEM backpressure for three cycles.
        io.MEM_allowin = 1'b0;
        issue(mk(pc_cnt, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 4'hF, 19'd1, 32'h1000, 32'd8));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_stall_allowin", 71'(io.EXE_allowin), 71'(0));
            check("st_stall_en", 71'(io.data_sram_en), 71'(0));
            tick();
        end
        io.MEM_allowin = 1'b1;
        @(negedge clk);
        check("st_en", 71'(io.data_sram_en), 71'(1));
        check("st_addr", 71'(io.data_sram_addr), 71'(32'h1008));
        check("st_wdata", 71'(io.data_sram_wdata), 71'(32'hDEAD_BEEF));
        check("st_we", 71'(io.data_sram_we), 71'(4'hF));
        tick();
        @(negedge clk);
        check("st_single_pulse", 71'(io.data_sram_en), 71'(0));
        tick();

        op_check("div", 19'd1 << 15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        op_check("mod", 19'd1 << 17, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        op_check("divu", 19'd1 << 16, 32'd7, 32'd2, 32'd3, 33);
        op_check("divu_by0", 19'd1 << 16, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);
        op_check("modu_by0", 19'd1 << 18, 32'd9, 32'd0, 32'd9, 33);
        op_check("div_ovf", 19'd1 << 15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        op_check("mulh", 19'd1 << 13, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0);
        op_check("mulhu", 19'd1 << 14, 32'h8000_0000, 32'd2, 32'd1, 0);
        op_check("mul", 19'd1 << 12, 32'h1_0000, 32'h1_0000, 32'd0, 0);

        // Reset in the middle of a divide: nothing may be emitted afterwards.
        issue(mk(pc_cnt, 1'b1, 5'd7, 32'd0, 1'b0, 4'h0, 19'd1 << 15, 32'd100, 32'd7));
        repeat (10) tick();
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_mem_valid", 71'(io.MEM_signal_valid), 71'(0));
        check("midrst_allowin", 71'(io.EXE_allowin), 71'(1));
        check("midrst_rf_we", 71'(io.EXE_rf_we), 71'(0));
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= io.MEM_signal_valid;
        end
        check("midrst_no_emit", 71'(seen), 71'(0));
        tick();
        op_check("add_after_rst", 19'd1, 32'd10, 32'd20, 32'd30, 0);
        op_check("div_after_rst", 19'd1 << 15, 32'd100, 32'd7, 32'd14, 33);

        // Random ops under random MEM backpressure.
        bp_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            k  = $urandom_range(0, 19);
            op = (k == 19) ? 19'd0 : (19'd1 << k);
            a  = $urandom();
            b  = $urandom();
            if (k >= 15 && k <= 18 && $urandom_range(0, 3) == 0) b = 32'd0;
            rfm = 1'b0;
            mwe = 4'h0;
            if ($urandom_range(0, 3) == 0) begin
                rfm = 1'($urandom_range(0, 1));
                mwe = rfm ? 4'h0 : 4'($urandom_range(1, 15));
            end
            issue(mk(pc_cnt, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                     rfm, mwe, op, a, b));
            if ($urandom_range(0, 3) == 0) tick();
        end
        bp_mode = 1'b0;
        io.MEM_allowin = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 71'(sb.size()), 71'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
